// File: rtl/ksa_param.sv
// ksa_param: parametrised RC4-style key-scheduling engine.
//
// Drives a single-port synchronous S-box RAM. It optionally fills the RAM with
// the identity permutation (S[i] = i) and then runs the key-scheduling swap
// pass: for each i, j += S[i] + key[i mod key_len], then swap S[i] and S[j].
//
// Handshake: the controller raises en. The request is taken on a clock edge
// where en = 1 and rdy = 1. rdy stays low until the run ends. done pulses
// for one cycle, which is the first idle cycle. A new en may be raised in
// that same cycle.
//
// Ports:
//   clk      clock
//   rst      synchronous, active-high reset (aborts a run, no done pulse)
//   en       start request, accepted only while rdy = 1
//   rdy      high while idle
//   done     one-cycle completion pulse
//   key      key bytes, byte 0 in the most significant byte
//   key_len  active key bytes (0 or > KEY_BYTES means KEY_BYTES)
//   addr     S-box address
//   rddata   S-box read data, valid the cycle after addr
//   wrdata   S-box write data
//   wren     S-box write enable
module ksa_param #(
  parameter int KEY_BYTES = 3,
  parameter int ADDR_W    = 8,
  parameter int INIT_EN   = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  output logic                             rdy,
  output logic                             done,
  input  logic [KEY_BYTES*8-1:0]           key,
  input  logic [$clog2(KEY_BYTES+1)-1:0]   key_len,
  output logic [ADDR_W-1:0]                addr,
  input  logic [ADDR_W-1:0]                rddata,
  output logic [ADDR_W-1:0]                wrdata,
  output logic                             wren
);

  localparam int KL_W   = $clog2(KEY_BYTES + 1);
  localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_READ_I,
    ST_WAIT_I,
    ST_READ_J,
    ST_WAIT_J,
    ST_WRITE_I,
    ST_WRITE_J
  } state_t;

  state_t                 state;
  logic [ADDR_W-1:0]      i;
  logic [ADDR_W-1:0]      j;
  logic [ADDR_W-1:0]      si;
  logic [ADDR_W-1:0]      sj;
  logic [KIDX_W-1:0]      kidx;
  logic [KIDX_W-1:0]      klast;      // index of the last active key byte
  logic [KEY_BYTES*8-1:0] key_q;

  logic [KIDX_W-1:0]      klast_next;
  logic [KEY_BYTES*8-1:0] key_sh;
  logic [7:0]             kbyte;
  logic [ADDR_W-1:0]      kb;

  // Out-of-range lengths fall back to the full key.
  always_comb begin
    klast_next = KIDX_W'(KEY_BYTES - 1);
    if (key_len != '0 && key_len <= KL_W'(KEY_BYTES)) begin
      klast_next = KIDX_W'(key_len - KL_W'(1));
    end
  end

  // Byte kidx sits at the top after shifting left by kidx bytes.
  // The cast truncates for narrow S-boxes and zero-extends for wide ones.
  always_comb begin
    key_sh = key_q << {kidx, 3'b000};
    kbyte  = key_sh[KEY_BYTES*8-1 -: 8];
    kb     = ADDR_W'(kbyte);
  end

  // RAM-side outputs are a pure decode of the current state.
  always_comb begin
    addr   = '0;
    wrdata = '0;
    wren   = 1'b0;
    case (state)
      ST_INIT: begin
        addr   = i;
        wrdata = i;
        wren   = 1'b1;
      end
      ST_READ_I, ST_WAIT_I: addr = i;
      ST_READ_J, ST_WAIT_J: addr = j;
      ST_WRITE_I: begin
        addr   = i;
        wrdata = sj;
        wren   = 1'b1;
      end
      ST_WRITE_J: begin
        // When i == j this overwrites the WRITE_I value with Si, so the
        // swap degenerates to a no-op without special handling.
        addr   = j;
        wrdata = si;
        wren   = 1'b1;
      end
      default: ;
    endcase
  end

  assign rdy = (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      i     <= '0;
      j     <= '0;
      kidx  <= '0;
      si    <= '0;
      sj    <= '0;
      klast <= '0;
      key_q <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en) begin
            key_q <= key;
            klast <= klast_next;
            i     <= '0;
            j     <= '0;
            kidx  <= '0;
            state <= (INIT_EN != 0) ? ST_INIT : ST_READ_I;
          end
        end
        ST_INIT: begin
          // i wraps to 0 naturally after the last identity write.
          i <= i + ADDR_W'(1);
          if (&i) state <= ST_READ_I;
        end
        ST_READ_I: state <= ST_WAIT_I;
        ST_WAIT_I: begin
          si    <= rddata;
          j     <= j + rddata + kb;
          state <= ST_READ_J;
        end
        ST_READ_J: state <= ST_WAIT_J;
        ST_WAIT_J: begin
          sj    <= rddata;
          state <= ST_WRITE_I;
        end
        ST_WRITE_I: state <= ST_WRITE_J;
        ST_WRITE_J: begin
          kidx <= (kidx == klast) ? '0 : kidx + KIDX_W'(1);
          if (&i) begin
            i     <= '0;
            done  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            i     <= i + ADDR_W'(1);
            state <= ST_READ_I;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
